// File: rtl/data_bus_demux_pkg.sv
// Shared bus constants, target index type and the default SoC address map
// used by the data bus splitter.
package data_bus_demux_pkg;

    localparam int BUS_AW     = 32;
    localparam int BUS_DW     = 32;
    localparam int MAX_SLAVES = 8;
    localparam int TGT_W      = 4;

    // Wide enough for slave indices 0..7 plus the internal error target.
    typedef logic [TGT_W-1:0] tgt_idx_t;

    typedef enum logic [1:0] {
        SLV_RAM   = 2'd0,
        SLV_GPIO  = 2'd1,
        SLV_UART  = 2'd2,
        SLV_TIMER = 2'd3
    } soc_slv_e;

    localparam int       SOC_NUM_SLAVES = 4;
    localparam tgt_idx_t ERR_TGT        = tgt_idx_t'(SOC_NUM_SLAVES);

    localparam logic [SOC_NUM_SLAVES-1:0][BUS_AW-1:0] SOC_SLV_BASE = {
        32'h1000_2000,
        32'h1000_1000,
        32'h1000_0000,
        32'h0000_0000
    };

    localparam logic [SOC_NUM_SLAVES-1:0][BUS_AW-1:0] SOC_SLV_MASK = {
        32'hFFFF_F000,
        32'hFFFF_F000,
        32'hFFFF_F000,
        32'hFFFF_0000
    };

    // The error target always sits one past the last real slave.
    function automatic tgt_idx_t err_tgt(input int num_slaves);
        return tgt_idx_t'(num_slaves);
    endfunction

endpackage

// File: rtl/data_bus_demux_if.sv
// Core data bus between the processor and the splitter, plus the broadcast
// slave-side bus from the splitter to its N slaves.
interface data_bus_demux_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic                             data_req;
    logic                             data_we;
    logic [BE_W-1:0]                  data_be;
    logic [ADDR_WIDTH-1:0]            data_addr;
    logic [DATA_WIDTH-1:0]            data_wdata;
    logic                             data_gnt;
    logic                             data_rvalid;
    logic [DATA_WIDTH-1:0]            data_rdata;
    logic                             data_err;

    logic [NUM_SLAVES-1:0]            s_req;
    logic                             s_we;
    logic [BE_W-1:0]                  s_be;
    logic [ADDR_WIDTH-1:0]            s_addr;
    logic [DATA_WIDTH-1:0]            s_wdata;
    logic [NUM_SLAVES-1:0]            s_gnt;
    logic [NUM_SLAVES-1:0]            s_rvalid;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]            s_err;

    // Processor side of the core bus.
    modport master (
        output data_req, data_we, data_be, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata, data_err
    );

    // Splitter side of the core bus.
    modport slave (
        input  data_req, data_we, data_be, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata, data_err
    );

    // Splitter driving the slave ports.
    modport fabric (
        output s_req, s_we, s_be, s_addr, s_wdata,
        input  s_gnt, s_rvalid, s_rdata, s_err
    );

    // Slave population answering the splitter.
    modport periph (
        input  s_req, s_we, s_be, s_addr, s_wdata,
        output s_gnt, s_rvalid, s_rdata, s_err
    );

endinterface

// File: rtl/data_bus_demux_decode.sv
// Pure combinational address decoder: base/mask match per slave, lowest index
// wins on overlap, no match selects the error target.
module data_bus_demux_decode
    import data_bus_demux_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLV_MASK = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  hit,
    output tgt_idx_t              tgt
);

    always_comb begin
        hit = 1'b0;
        tgt = err_tgt(NUM_SLAVES);
        // Scan downwards so the lowest matching index is the last one written.
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i]) == SLV_BASE[i]) begin
                hit = 1'b1;
                tgt = tgt_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/data_bus_demux.sv
// 1-to-N data bus splitter: decodes the address, forwards requests to one slave,
// tracks outstanding transactions and returns responses in issue order.
module data_bus_demux
    import data_bus_demux_pkg::*;
#(
    parameter int NUM_SLAVES      = 4,
    parameter int ADDR_WIDTH      = BUS_AW,
    parameter int DATA_WIDTH      = BUS_DW,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLV_MASK = '0
) (
    input  logic              clk,
    input  logic              rst,
    data_bus_demux_if.slave   mst,
    data_bus_demux_if.fabric  slv,
    output logic              proto_fault
);

    localparam int                CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam tgt_idx_t          TGT_ERR  = err_tgt(NUM_SLAVES);

    logic                  dec_hit;
    tgt_idx_t              dec_tgt;
    tgt_idx_t              cur_tgt;
    logic [CNT_W-1:0]      cnt;
    logic                  err_pend;
    logic                  pf_q;

    logic                  allow;
    logic                  issue;
    logic                  tgt_gnt;
    logic                  hs;
    logic                  rsp;
    logic [NUM_SLAVES-1:0] req_vec;
    logic [NUM_SLAVES-1:0] spur;
    logic                  cur_rvalid;
    logic [DATA_WIDTH-1:0] cur_rdata;
    logic                  cur_err;

    data_bus_demux_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_decode (
        .addr (mst.data_addr),
        .hit  (dec_hit),
        .tgt  (dec_tgt)
    );

    // A new target may only be opened once everything in flight has drained,
    // which is what keeps responses in issue order across slaves.
    assign allow = !rst && (cnt < CNT_MAX) && ((cnt == '0) || (dec_tgt == cur_tgt));
    assign issue = allow && mst.data_req;

    always_comb begin
        tgt_gnt = 1'b0;
        req_vec = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dec_hit && (dec_tgt == tgt_idx_t'(i))) begin
                tgt_gnt    = slv.s_gnt[i];
                req_vec[i] = issue;
            end
        end
    end

    // Unmapped accesses are accepted immediately and answered by err_pend.
    assign mst.data_gnt = issue && (dec_hit ? tgt_gnt : 1'b1);
    assign hs           = mst.data_gnt;

    assign slv.s_req   = req_vec;
    assign slv.s_we    = !rst && mst.data_we;
    assign slv.s_be    = rst ? '0 : mst.data_be;
    assign slv.s_addr  = rst ? '0 : mst.data_addr;
    assign slv.s_wdata = rst ? '0 : mst.data_wdata;

    // Response select; any rvalid not belonging to the open target is spurious.
    always_comb begin
        cur_rvalid = 1'b0;
        cur_rdata  = '0;
        cur_err    = 1'b0;
        spur       = slv.s_rvalid;
        if (cur_tgt == TGT_ERR) begin
            cur_rvalid = err_pend;
            cur_err    = 1'b1;
        end else begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if ((cur_tgt == tgt_idx_t'(i)) && (cnt != '0)) begin
                    cur_rvalid = slv.s_rvalid[i];
                    cur_rdata  = slv.s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                    cur_err    = slv.s_err[i];
                    spur[i]    = 1'b0;
                end
            end
        end
    end

    assign rsp             = !rst && cur_rvalid;
    assign mst.data_rvalid = rsp;
    assign mst.data_rdata  = rsp ? cur_rdata : '0;
    assign mst.data_err    = rsp && cur_err;
    assign proto_fault     = !rst && pf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            cur_tgt  <= '0;
            err_pend <= 1'b0;
            pf_q     <= 1'b0;
        end else begin
            if (hs) begin
                cur_tgt <= dec_tgt;
            end
            if (hs && !rsp) begin
                cnt <= cnt + CNT_ONE;
            end else if (!hs && rsp) begin
                cnt <= cnt - CNT_ONE;
            end
            err_pend <= hs && !dec_hit;
            pf_q     <= |spur;
        end
    end

endmodule

// File: tb/tb_data_bus_demux.sv
// Randomized scoreboard bench for the data bus splitter against an
// address-range reference model of the default SoC map.
module tb_data_bus_demux;
    import data_bus_demux_pkg::*;

    localparam int NS   = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 2;
    localparam int NCYC = 3000;
    localparam int ERRT = NS;

    typedef struct {
        int          tgt;
        logic [31:0] rdata;
        logic        err;
        int          resp;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    logic proto_fault;

    always #5 clk = ~clk;

    data_bus_demux_if #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    data_bus_demux #(
        .NUM_SLAVES      (NS),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAXO),
        .SLV_BASE        (SOC_SLV_BASE),
        .SLV_MASK        (SOC_SLV_MASK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mst         (bus),
        .slv         (bus),
        .proto_fault (proto_fault)
    );

    txn_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic last_hs = 1'b0;
    logic spur_now = 1'b0;
    logic spur_prev = 1'b0;
    logic pend;
    int   region;

    always @(posedge clk) cyc <= cyc + 1;

    // SoC map expressed as plain address ranges.
    function automatic int ref_tgt(input logic [31:0] a);
        if (a < 32'h0001_0000) return 0;
        if (a >= 32'h1000_0000 && a < 32'h1000_1000) return 1;
        if (a >= 32'h1000_1000 && a < 32'h1000_2000) return 2;
        if (a >= 32'h1000_2000 && a < 32'h1000_3000) return 3;
        return ERRT;
    endfunction

    function automatic logic [31:0] gen_addr(input int r);
        logic [31:0] off;
        off = 32'($urandom_range(32'hFFF)) & 32'hFFFF_FFFC;
        case (r)
            0:       return 32'h0000_0000 + (32'($urandom_range(32'hFFFF)) & 32'hFFFC);
            1:       return 32'h1000_0000 + off;
            2:       return 32'h1000_1000 + off;
            3:       return 32'h1000_2000 + off;
            default: return ($urandom_range(1) == 1) ? 32'h2000_0000 + off : 32'h1000_3000 + off;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor / scoreboard: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        int              tgt;
        int              lat;
        logic            allow_m;
        logic            exp_gnt;
        logic [NS-1:0]   exp_sreq;
        logic            exp_rv;
        txn_t            t;
        if (rst) begin
            chk("rst_gnt", 64'(bus.data_gnt), 64'(0));
            chk("rst_sreq", 64'(bus.s_req), 64'(0));
            chk("rst_rvalid", 64'(bus.data_rvalid), 64'(0));
            chk("rst_pf", 64'(proto_fault), 64'(0));
            sb.delete();
            last_hs = 1'b0;
        end else begin
            tgt      = ref_tgt(bus.data_addr);
            allow_m  = (sb.size() < MAXO) && (sb.size() == 0 || sb[0].tgt == tgt);
            exp_gnt  = bus.data_req && allow_m && (tgt == ERRT || bus.s_gnt[tgt] == 1'b1);
            exp_sreq = '0;
            if (bus.data_req && allow_m && tgt != ERRT) exp_sreq[tgt] = 1'b1;
            chk("gnt", 64'(bus.data_gnt), 64'(exp_gnt));
            chk("s_req", 64'(bus.s_req), 64'(exp_sreq));
            chk("s_addr", 64'(bus.s_addr), 64'(bus.data_addr));

            exp_rv = (sb.size() > 0) && (sb[0].resp == cyc);
            chk("rvalid", 64'(bus.data_rvalid), 64'(exp_rv));
            if (exp_rv && bus.data_rvalid) begin
                chk("rdata", 64'(bus.data_rdata), 64'(sb[0].rdata));
                chk("err", 64'(bus.data_err), 64'(sb[0].err));
            end
            if (!bus.data_rvalid) chk("rdata_idle", 64'(bus.data_rdata), 64'(0));
            if (exp_rv) void'(sb.pop_front());
            chk("proto_fault", 64'(proto_fault), 64'(spur_prev));

            last_hs = bus.data_req && bus.data_gnt;
            if (last_hs) begin
                lat = (tgt == ERRT) ? 1 : $urandom_range(6, 1);
                t.tgt   = tgt;
                t.resp  = cyc + lat;
                if (sb.size() > 0 && sb[$].resp >= t.resp) t.resp = sb[$].resp + 1;
                t.rdata = (tgt == ERRT) ? 32'h0 : $urandom;
                t.err   = (tgt == ERRT) ? 1'b1 : ($urandom_range(7) == 0);
                sb.push_back(t);
            end
        end
        spur_prev = spur_now;
    end

    // Driver: master requests, random slave grants, slave responses, spurious pulses.
    initial begin
        int j;
        pend            = 1'b0;
        region          = 0;
        rst             = 1'b1;
        bus.data_req    = 1'b1;
        bus.data_we     = 1'b0;
        bus.data_be     = '1;
        bus.data_addr   = 32'h1000_0004;
        bus.data_wdata  = '0;
        bus.s_gnt       = '1;
        bus.s_rvalid    = '0;
        bus.s_rdata     = '0;
        bus.s_err       = '0;
        repeat (3) @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.data_req = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            rst = (c >= 1500 && c < 1502);
            if (!pend || last_hs) begin
                pend = (c < NCYC - 40) && ($urandom_range(99) < 60);
                if (pend) begin
                    if ($urandom_range(99) < 30) region = $urandom_range(4);
                    bus.data_addr  = gen_addr(region);
                    bus.data_we    = 1'($urandom_range(1));
                    bus.data_be    = 4'($urandom);
                    bus.data_wdata = $urandom;
                end
            end
            bus.data_req = pend;
            bus.s_gnt    = 4'($urandom) | 4'($urandom);
            bus.s_rvalid = '0;
            bus.s_err    = '0;
            bus.s_rdata  = {$urandom, $urandom, $urandom, $urandom};
            spur_now     = 1'b0;
            if (sb.size() > 0 && sb[0].resp == cyc && sb[0].tgt != ERRT) begin
                bus.s_rvalid[sb[0].tgt]           = 1'b1;
                bus.s_rdata[sb[0].tgt*DW +: DW]   = sb[0].rdata;
                bus.s_err[sb[0].tgt]              = sb[0].err;
            end
            if (!rst && $urandom_range(39) == 0) begin
                j = $urandom_range(NS - 1);
                if (sb.size() == 0 || sb[0].tgt != j) begin
                    bus.s_rvalid[j] = 1'b1;
                    spur_now        = 1'b1;
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_outstanding", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
